// File: rtl/vproc_timer_pkg.sv
// Shared definitions for the VProc timer: register offsets, CTRL bit
// positions, bus FSM states and the byte-enable mask helper.
package vproc_timer_pkg;

  // Register select values on Addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LOAD   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // CTRL bit positions
  localparam int unsigned CTRL_EN        = 32'd0;
  localparam int unsigned CTRL_RELOAD    = 32'd1;
  localparam int unsigned CTRL_IRQ_EN    = 32'd2;
  localparam int unsigned CTRL_PRESC_LSB = 32'd8;

  // STATUS bit positions
  localparam int unsigned STATUS_EXP = 32'd0;

  // Bus handshake states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } bus_state_t;

  // Expand four byte enables into a 32-bit bit mask
  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = 32'd0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/vproc_timer_core.sv
// Down-counter datapath of the VProc timer: COUNT, the EXP flag, the
// one-shot EN-clear request and (with VPROC_TIMER_PRESCALE_EN) the
// 8-bit prescaler that divides the tick rate by PRESC+1.
module vproc_timer_core #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 en,
  input  logic                 reload,
`ifdef VPROC_TIMER_PRESCALE_EN
  input  logic [7:0]           presc,
  input  logic                 ctrl_wr,
`endif
  input  logic                 load_wr,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic [CNT_WIDTH-1:0] load_reg,
  input  logic                 exp_w1c,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 exp,
  output logic                 en_clr
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1'b1);

  logic [CNT_WIDTH-1:0] count_r;
  logic                 exp_r;
  logic                 tick_s;
  logic                 zero_s;

`ifdef VPROC_TIMER_PRESCALE_EN
  logic [7:0] presc_cnt_r;

  // Prescaler: free-runs 0..PRESC while enabled, restarts on CTRL writes
  always_ff @(posedge clk) begin
    if (!nreset) begin
      presc_cnt_r <= 8'd0;
    end else if (ctrl_wr || !en) begin
      presc_cnt_r <= 8'd0;
    end else if (presc_cnt_r == presc) begin
      presc_cnt_r <= 8'd0;
    end else begin
      presc_cnt_r <= presc_cnt_r + 8'd1;
    end
  end
`endif

  // Tick generation and expiry detection
  always_comb begin
    zero_s = (count_r == CNT_ZERO);
`ifdef VPROC_TIMER_PRESCALE_EN
    tick_s = en & (presc_cnt_r == presc);
`else
    tick_s = en;
`endif
    en_clr = tick_s & zero_s & ~reload;
  end

  // COUNT: a LOAD write overrides the tick; expiry either reloads or parks at zero
  always_ff @(posedge clk) begin
    if (!nreset) begin
      count_r <= CNT_ZERO;
    end else if (load_wr) begin
      count_r <= load_val;
    end else if (tick_s) begin
      if (!zero_s) begin
        count_r <= count_r - CNT_ONE;
      end else if (reload) begin
        count_r <= load_reg;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // EXP flag: set on expiry tick, which wins over a same-cycle write-1-to-clear
  always_ff @(posedge clk) begin
    if (!nreset) begin
      exp_r <= 1'b0;
    end else if (tick_s && zero_s) begin
      exp_r <= 1'b1;
    end else if (exp_w1c) begin
      exp_r <= 1'b0;
    end
  end

  assign count = count_r;
  assign exp   = exp_r;

endmodule

// File: rtl/vproc_timer.sv
// VProc memory-mapped down-counter timer: segment decode, one-shot
// acknowledge handshake, CTRL/LOAD registers and registered interrupt.
// Optional feature macro: VPROC_TIMER_PRESCALE_EN adds CTRL[15:8] PRESC.
module vproc_timer
  import vproc_timer_pkg::*;
#(
  parameter logic [3:0] BASE_SEG  = 4'hc,
  parameter int         CNT_WIDTH = 32
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic        RD,
  input  logic [3:0]  BE,
  input  logic [31:0] DI,
  output logic [31:0] DO,
  output logic        WRAck,
  output logic        RDAck,
  output logic        Irq
);

  bus_state_t           state_r;
  logic [31:0]          do_r;
  logic                 wrack_r;
  logic                 rdack_r;
  logic                 irq_r;

  logic                 en_r;
  logic                 reload_r;
  logic                 irq_en_r;
  logic [CNT_WIDTH-1:0] load_r;
`ifdef VPROC_TIMER_PRESCALE_EN
  logic [7:0]           presc_r;
`endif

  logic                 cs_s;
  logic                 wr_go_s;
  logic                 rd_go_s;
  logic                 wr_ctrl_s;
  logic                 wr_load_s;
  logic                 wr_status_s;
  logic                 exp_w1c_s;
  logic [31:0]          be_mask_s;
  logic [CNT_WIDTH-1:0] load_next_s;
  logic [31:0]          rdata_s;
  logic [CNT_WIDTH-1:0] count_s;
  logic                 exp_s;
  logic                 en_clr_s;
  logic                 unused_addr_s;

  assign unused_addr_s = ^{Addr[27:4], Addr[1:0]};

  // Address decode and write-strobe generation; accesses only start from IDLE
  always_comb begin
    cs_s        = (Addr[31:28] == BASE_SEG) & (WE | RD);
    wr_go_s     = (state_r == IDLE) & cs_s & WE;
    rd_go_s     = (state_r == IDLE) & cs_s & ~WE;
    wr_ctrl_s   = wr_go_s & (Addr[3:2] == REG_CTRL);
    wr_load_s   = wr_go_s & (Addr[3:2] == REG_LOAD);
    wr_status_s = wr_go_s & (Addr[3:2] == REG_STATUS);
    exp_w1c_s   = wr_status_s & BE[0] & DI[STATUS_EXP];
    be_mask_s   = be_to_mask(BE);
    load_next_s = (load_r & ~be_mask_s[CNT_WIDTH-1:0]) |
                  (DI[CNT_WIDTH-1:0] & be_mask_s[CNT_WIDTH-1:0]);
  end

  // Read data mux; unused bits read as zero
  always_comb begin
    rdata_s = 32'd0;
    case (Addr[3:2])
      REG_CTRL: begin
        rdata_s[CTRL_EN]     = en_r;
        rdata_s[CTRL_RELOAD] = reload_r;
        rdata_s[CTRL_IRQ_EN] = irq_en_r;
`ifdef VPROC_TIMER_PRESCALE_EN
        rdata_s[CTRL_PRESC_LSB +: 8] = presc_r;
`endif
      end
      REG_LOAD:   rdata_s[CNT_WIDTH-1:0] = load_r;
      REG_COUNT:  rdata_s[CNT_WIDTH-1:0] = count_s;
      REG_STATUS: rdata_s[STATUS_EXP]    = exp_s;
      default:    rdata_s = 32'd0;
    endcase
  end

  // Bus FSM: one-cycle ack, then wait for the strobe to drop so a held request is not repeated
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r <= IDLE;
      do_r    <= 32'd0;
      wrack_r <= 1'b0;
      rdack_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wrack_r <= wr_go_s;
          rdack_r <= rd_go_s;
          if (rd_go_s) begin
            do_r <= rdata_s;
          end
          if (wr_go_s || rd_go_s) begin
            state_r <= ACK;
          end
        end
        ACK: begin
          wrack_r <= 1'b0;
          rdack_r <= 1'b0;
          state_r <= HOLD;
        end
        HOLD: begin
          wrack_r <= 1'b0;
          rdack_r <= 1'b0;
          if (!WE && !RD) begin
            state_r <= IDLE;
          end
        end
        default: begin
          wrack_r <= 1'b0;
          rdack_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // CTRL and LOAD registers; a bus write to EN wins over the one-shot auto-clear
  always_ff @(posedge clk) begin
    if (!nreset) begin
      en_r     <= 1'b0;
      reload_r <= 1'b0;
      irq_en_r <= 1'b0;
      load_r   <= {CNT_WIDTH{1'b0}};
`ifdef VPROC_TIMER_PRESCALE_EN
      presc_r  <= 8'd0;
`endif
    end else begin
      if (wr_ctrl_s && BE[0]) begin
        en_r     <= DI[CTRL_EN];
        reload_r <= DI[CTRL_RELOAD];
        irq_en_r <= DI[CTRL_IRQ_EN];
      end else if (en_clr_s) begin
        en_r <= 1'b0;
      end
`ifdef VPROC_TIMER_PRESCALE_EN
      if (wr_ctrl_s && BE[1]) begin
        presc_r <= DI[CTRL_PRESC_LSB +: 8];
      end
`endif
      if (wr_load_s) begin
        load_r <= load_next_s;
      end
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk) begin
    if (!nreset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= exp_s & irq_en_r;
    end
  end

  vproc_timer_core #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_core (
    .clk      (clk),
    .nreset   (nreset),
    .en       (en_r),
    .reload   (reload_r),
`ifdef VPROC_TIMER_PRESCALE_EN
    .presc    (presc_r),
    .ctrl_wr  (wr_ctrl_s),
`endif
    .load_wr  (wr_load_s),
    .load_val (load_next_s),
    .load_reg (load_r),
    .exp_w1c  (exp_w1c_s),
    .count    (count_s),
    .exp      (exp_s),
    .en_clr   (en_clr_s)
  );

  assign DO    = do_r;
  assign WRAck = wrack_r;
  assign RDAck = rdack_r;
  assign Irq   = irq_r;

endmodule

// File: tb/tb_vproc_timer.sv
// Self-checking bench for vproc_timer: reset, a table of bus vectors,
// hand-written timing sequences and a randomized run against an
// arithmetic model of the counter.
module tb_vproc_timer;

  logic        clk;
  logic        nreset;
  logic [31:0] Addr;
  logic        WE;
  logic        RD;
  logic [3:0]  BE;
  logic [31:0] DI;
  logic [31:0] DO;
  logic        WRAck;
  logic        RDAck;
  logic        Irq;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [31:0] A_CTRL   = 32'hc000_0000;
  localparam logic [31:0] A_LOAD   = 32'hc000_0004;
  localparam logic [31:0] A_COUNT  = 32'hc000_0008;
  localparam logic [31:0] A_STATUS = 32'hc000_000c;
`ifdef VPROC_TIMER_PRESCALE_EN
  localparam logic [31:0] CTRL_RB  = 32'h0000_ff00;
`else
  localparam logic [31:0] CTRL_RB  = 32'h0000_0000;
`endif

  vproc_timer dut (
    .clk    (clk),
    .nreset (nreset),
    .Addr   (Addr),
    .WE     (WE),
    .RD     (RD),
    .BE     (BE),
    .DI     (DI),
    .DO     (DO),
    .WRAck  (WRAck),
    .RDAck  (RDAck),
    .Irq    (Irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One complete bus access; returns read data and the cycle index of the capture edge
  task automatic bus_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] di, input logic exp_ack,
                            output logic [31:0] rdata, output int cap);
    @(negedge clk);
    Addr = addr; WE = we; RD = ~we; BE = be; DI = di;
    @(posedge clk); #1;
    cap   = cyc;
    rdata = DO;
    check($sformatf("ack@%h", addr), {30'd0, WRAck, RDAck},
          exp_ack ? (we ? 32'd2 : 32'd1) : 32'd0);
    WE = 1'b0; RD = 1'b0;
    @(posedge clk); #1;
    check($sformatf("ackpulse@%h", addr), {30'd0, WRAck, RDAck}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] di, output int cap);
    logic [31:0] d;
    bus_access(1'b1, addr, 4'hf, di, 1'b1, d, cap);
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp, output int cap);
    logic [31:0] d;
    bus_access(1'b0, addr, 4'hf, 32'd0, 1'b1, d, cap);
    check(name, d, exp);
  endtask

  // Poll Irq for a bounded number of cycles; first = -1 on timeout
  task automatic wait_irq(output int first);
    first = -1;
    for (int i = 0; i < 40; i++) begin
      if (Irq === 1'b1) begin
        first = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  // Reference model: COUNT after t ticks starting from LOAD=l
  function automatic int model_count(input int l, input bit rel, input int t);
    if (rel) return l - (t % (l + 1));
    if (t >= l) return 0;
    return l - t;
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] di;
    logic        exp_ack;
    logic        chk_do;
    logic [31:0] exp_do;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int cap, w, first, c;
    logic [31:0] d;

    vecs[0]  = '{1'b0, A_CTRL,        4'hf, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[1]  = '{1'b0, A_COUNT,       4'hf, 32'h0,         1'b1, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, A_LOAD,        4'hf, 32'd5,         1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, A_COUNT,       4'hf, 32'h0,         1'b1, 1'b1, 32'd5};
    vecs[4]  = '{1'b0, A_LOAD,        4'hf, 32'h0,         1'b1, 1'b1, 32'd5};
    vecs[5]  = '{1'b1, A_LOAD,        4'hf, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[6]  = '{1'b1, A_LOAD,        4'h1, 32'haabbccdd,  1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, A_LOAD,        4'hf, 32'h0,         1'b1, 1'b1, 32'hdd};
    vecs[8]  = '{1'b1, A_COUNT,       4'hf, 32'h1234,      1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, A_COUNT,       4'hf, 32'h0,         1'b1, 1'b1, 32'hdd};
    vecs[10] = '{1'b1, A_CTRL,        4'hf, 32'hffffff00,  1'b1, 1'b0, 32'h0};
    vecs[11] = '{1'b0, A_CTRL,        4'hf, 32'h0,         1'b1, 1'b1, CTRL_RB};
    vecs[12] = '{1'b1, 32'ha000_0004, 4'hf, 32'h55,        1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'ha000_0004, 4'hf, 32'h0,         1'b0, 1'b1, CTRL_RB};
    vecs[14] = '{1'b0, A_LOAD,        4'hf, 32'h0,         1'b1, 1'b1, 32'hdd};
    vecs[15] = '{1'b0, A_STATUS,      4'hf, 32'h0,         1'b1, 1'b1, 32'h0};

    Addr = 32'd0; WE = 1'b0; RD = 1'b0; BE = 4'h0; DI = 32'd0;

    // Reset held for three cycles
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_do",    DO,              32'd0);
    check("rst_acks",  {30'd0, WRAck, RDAck}, 32'd0);
    check("rst_irq",   {31'd0, Irq},    32'd0);
    nreset = 1'b1;

    // Table-driven access, byte-enable and decode vectors
    for (int i = 0; i < 16; i++) begin
      bus_access(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].di, vecs[i].exp_ack, d, cap);
      if (vecs[i].chk_do) check($sformatf("vec%0d_do", i), d, vecs[i].exp_do);
    end

    // Reset in the cycle after a write is captured: no ack follows, write discarded
    @(negedge clk);
    Addr = A_LOAD; WE = 1'b1; BE = 4'hf; DI = 32'h77;
    @(posedge clk); #1;
    check("midrst_ack", {31'd0, WRAck}, 32'd1);
    nreset = 1'b0; WE = 1'b0;
    @(posedge clk); #1;
    check("midrst_noack", {30'd0, WRAck, RDAck}, 32'd0);
    nreset = 1'b1;
    rd_chk("midrst_load", A_LOAD, 32'd0, cap);

    // One-shot: LOAD=3, EN|IRQ_EN -> Irq first seen 5 edges after the CTRL write
    wr(A_LOAD, 32'd3, cap);
    wr(A_CTRL, 32'h5, w);
    wait_irq(first);
    check("oneshot_irq_time", 32'(first - w), 32'd5);
    rd_chk("oneshot_status", A_STATUS, 32'd1, cap);
    rd_chk("oneshot_ctrl",   A_CTRL,   32'h4, cap);
    rd_chk("oneshot_count",  A_COUNT,  32'd0, cap);
    wr(A_STATUS, 32'd1, cap);
    check("oneshot_w1c_irq", {31'd0, Irq}, 32'd0);

    // Periodic: LOAD=2 -> expiries at w+3, w+6, ...; W1C at w+6 loses to the set
    wr(A_LOAD, 32'd2, cap);
    wr(A_CTRL, 32'h7, w);
    @(posedge clk); #1;
    check("periodic_irq_low", {31'd0, Irq}, 32'd0);
    @(posedge clk); #1;
    check("periodic_irq_high", {31'd0, Irq}, 32'd1);
    while (cyc < w + 5) begin
      @(posedge clk); #1;
    end
    wr(A_STATUS, 32'd1, cap);
    check("periodic_w1c_edge", 32'(cap - w), 32'd6);
    rd_chk("periodic_setwins", A_STATUS, 32'd1, cap);
    wr(A_CTRL, 32'h0, cap);
    wr(A_STATUS, 32'd1, cap);
    rd_chk("periodic_cleared", A_STATUS, 32'd0, cap);
    check("periodic_irq_off", {31'd0, Irq}, 32'd0);

`ifdef VPROC_TIMER_PRESCALE_EN
    // Prescale: PRESC=3, LOAD=1 -> EXP 8 edges after enable, Irq one later
    wr(A_LOAD, 32'd1, cap);
    wr(A_CTRL, 32'h0305, w);
    wait_irq(first);
    check("presc_irq_time", 32'(first - w), 32'd9);
    wr(A_CTRL, 32'h0, cap);
    wr(A_STATUS, 32'd1, cap);
`endif

    // Randomized configurations checked against the arithmetic model
    for (int it = 0; it < 16; it++) begin
      int l, t, ecount;
      bit rel, ie, expd;
      l   = int'($urandom_range(0, 6));
      rel = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      wr(A_CTRL, 32'h0, cap);
      wr(A_STATUS, 32'd1, cap);
      wr(A_LOAD, 32'(l), cap);
      wr(A_CTRL, {29'd0, ie, rel, 1'b1}, w);
      repeat ($urandom_range(0, 12)) begin
        @(posedge clk); #1;
      end
      bus_access(1'b0, A_COUNT, 4'hf, 32'd0, 1'b1, d, cap);
      t = cap - 1 - w;
      ecount = model_count(l, rel, t);
      check($sformatf("rand%0d_count", it), d, 32'(ecount));
      bus_access(1'b0, A_STATUS, 4'hf, 32'd0, 1'b1, d, cap);
      t = cap - 1 - w;
      expd = (t >= l + 1);
      check($sformatf("rand%0d_exp", it), d, {31'd0, expd});
      c = cyc;
      expd = ((c - 1 - w) >= l + 1);
      check($sformatf("rand%0d_irq", it), {31'd0, Irq}, {31'd0, ie & expd});
      bus_access(1'b0, A_CTRL, 4'hf, 32'd0, 1'b1, d, cap);
      t = cap - 1 - w;
      expd = (t >= l + 1);
      check($sformatf("rand%0d_ctrl", it), d, {29'd0, ie, rel, rel | ~expd});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
